// File: rtl/dcpu16_marb.sv
// dcpu16_marb: round-robin arbiter of NCH strobe/ack masters onto one registered slave port.
// Build macro DCPU16_MARB_TIMEOUT_EN adds a BUSY watchdog that completes the cycle with m_err.
module dcpu16_marb #(
    parameter int AW  = 16,
    parameter int DW  = 16,
    parameter int NCH = 2,
    parameter int TOW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*AW-1:0] m_adr,
    input  logic [NCH*DW-1:0] m_dto,
    input  logic [NCH-1:0]    m_stb,
    input  logic [NCH-1:0]    m_wre,
    output logic [DW-1:0]     m_dti,
    output logic [NCH-1:0]    m_ack,
    output logic [NCH-1:0]    m_err,
    output logic [AW-1:0]     s_adr,
    output logic [DW-1:0]     s_dto,
    output logic              s_stb,
    output logic              s_wre,
    input  logic [DW-1:0]     s_dti,
    input  logic              s_ack
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t         r_state, w_state_nxt;
    logic [GW-1:0]  r_last, w_sel;
    logic           w_any, w_grant, w_done, w_tmo;
    logic [NCH-1:0] w_gnt_oh, r_ack;
    logic [AW-1:0]  r_s_adr;
    logic [DW-1:0]  r_s_dto, r_m_dti;
    logic           r_s_stb, r_s_wre;

    if (NCH < 2 || NCH > 8 || TOW < 1) begin : g_bad_cfg
        $error("dcpu16_marb: NCH must be 2..8 and TOW at least 1");
    end

    // Scan from last+NCH down to last+1 so the nearest requester after last wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_last;
        for (int k = NCH; k >= 1; k--) begin
            if (m_stb[GW'((int'(r_last) + k) % NCH)]) begin
                w_any = 1'b1;
                w_sel = GW'((int'(r_last) + k) % NCH);
            end
        end
    end

    assign w_gnt_oh = {{(NCH-1){1'b0}}, 1'b1} << r_last;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (s_ack || w_tmo) begin
                    w_done      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // r_last doubles as the current grant index while BUSY/ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last  <= GW'(NCH - 1);
            r_s_adr <= '0;
            r_s_dto <= '0;
            r_s_stb <= 1'b0;
            r_s_wre <= 1'b0;
            r_m_dti <= '0;
            r_ack   <= '0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_last  <= w_sel;
                r_s_adr <= m_adr[int'(w_sel)*AW +: AW];
                r_s_dto <= m_dto[int'(w_sel)*DW +: DW];
                r_s_wre <= m_wre[w_sel];
                r_s_stb <= 1'b1;
            end
            if (w_done) begin
                r_s_stb <= 1'b0;
                r_ack   <= w_gnt_oh;
                r_m_dti <= s_ack ? s_dti : '0;
            end
        end
    end

`ifdef DCPU16_MARB_TIMEOUT_EN
    logic [TOW-1:0] r_to, w_to_inc;
    logic [NCH-1:0] r_err;

    // Fires when the BUSY cycle now ending is the (2^TOW-1)th; a same-cycle s_ack wins.
    assign w_to_inc = r_to + TOW'(1);
    assign w_tmo    = (r_state == BUSY) && !s_ack && (w_to_inc == {TOW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to  <= '0;
            r_err <= '0;
        end else begin
            r_err <= w_tmo ? w_gnt_oh : '0;
            if (w_grant)              r_to <= '0;
            else if (r_state == BUSY) r_to <= w_to_inc;
        end
    end

    assign m_err = r_err;
`else
    assign w_tmo = 1'b0;
    assign m_err = '0;
`endif

    assign s_adr = r_s_adr;
    assign s_dto = r_s_dto;
    assign s_stb = r_s_stb;
    assign s_wre = r_s_wre;
    assign m_dti = r_m_dti;
    assign m_ack = r_ack;
endmodule

// File: tb/tb_dcpu16_marb.sv
// Bench for dcpu16_marb: directed cases plus randomized masters/slave against a round-robin reference model.
module tb_dcpu16_marb;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int NCH = 2;
    localparam int TOW = 4;

    logic              clk;
    logic              rst;
    logic [NCH*AW-1:0] m_adr;
    logic [NCH*DW-1:0] m_dto;
    logic [NCH-1:0]    m_stb;
    logic [NCH-1:0]    m_wre;
    logic [DW-1:0]     m_dti;
    logic [NCH-1:0]    m_ack;
    logic [NCH-1:0]    m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dto;
    logic              s_stb;
    logic              s_wre;
    logic [DW-1:0]     s_dti;
    logic              s_ack;

    dcpu16_marb #(.AW(AW), .DW(DW), .NCH(NCH), .TOW(TOW)) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_dto(m_dto), .m_stb(m_stb), .m_wre(m_wre),
        .m_dti(m_dti), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dto(s_dto), .s_stb(s_stb), .s_wre(s_wre),
        .s_dti(s_dti), .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int            ch;
        logic [DW-1:0] dat;
        logic          err;
        int            cyc;
    } exp_t;
    exp_t exp_q[$];

    function automatic int rr_pick(input logic [NCH-1:0] req, input int last);
        for (int k = 1; k <= NCH; k++)
            if (req[(last + k) % NCH]) return (last + k) % NCH;
        return -1;
    endfunction

    localparam int M_IDLE = 0, M_BUSY = 1, M_ACK = 2;
    int            mst, m_last, m_ch, busy_n, pick;
    bit            e_vld = 1'b0;
    logic          e_stb, e_wre;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dto, e_dti;

    initial forever begin
        @(negedge clk);
        if (e_vld) begin
            check("s_stb", 32'(s_stb), 32'(e_stb));
            check("s_adr", 32'(s_adr), 32'(e_adr));
            check("s_dto", 32'(s_dto), 32'(e_dto));
            check("s_wre", 32'(s_wre), 32'(e_wre));
            check("m_dti", 32'(m_dti), 32'(e_dti));
        end
        if (rst) begin
            e_vld  = 1'b1;
            mst    = M_IDLE;
            m_last = NCH - 1;
            e_stb  = 1'b0; e_wre = 1'b0;
            e_adr  = '0;   e_dto = '0;   e_dti = '0;
            exp_q.delete();
        end else if (e_vld) begin
            case (mst)
                M_IDLE: begin
                    pick = rr_pick(m_stb, m_last);
                    if (pick >= 0) begin
                        m_last = pick;
                        m_ch   = pick;
                        busy_n = 0;
                        mst    = M_BUSY;
                        e_stb  = 1'b1;
                        e_adr  = m_adr[pick*AW +: AW];
                        e_dto  = m_dto[pick*DW +: DW];
                        e_wre  = m_wre[pick];
                    end
                end
                M_BUSY: begin
                    busy_n++;
                    if (s_ack) begin
                        exp_q.push_back('{ch: m_ch, dat: s_dti, err: 1'b0, cyc: cyc + 1});
                        e_dti = s_dti;
                        e_stb = 1'b0;
                        mst   = M_ACK;
                    end
`ifdef DCPU16_MARB_TIMEOUT_EN
                    else if (busy_n == (1 << TOW) - 1) begin
                        exp_q.push_back('{ch: m_ch, dat: '0, err: 1'b1, cyc: cyc + 1});
                        e_dti = '0;
                        e_stb = 1'b0;
                        mst   = M_ACK;
                    end
`endif
                end
                default: mst = M_IDLE;
            endcase
        end
    end

    exp_t e;
    initial forever begin
        @(negedge clk);
        if (cyc >= 1) begin
            if (m_ack !== '0 || m_err !== '0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_ack: m_ack=%b m_err=%b with nothing outstanding (cycle %0d)", m_ack, m_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_vec",   32'(m_ack), 32'(1) << e.ch);
                    check("err_vec",   32'(m_err), e.err ? (32'(1) << e.ch) : 32'(0));
                    check("ack_dti",   32'(m_dti), 32'(e.dat));
                    check("ack_cycle", 32'(cyc),   32'(e.cyc));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                n_chk++;
                $display("FAIL missing_ack: ch%0d due in cycle %0d, none by cycle %0d", exp_q[0].ch, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus: slave and masters ----------------
    int            sl_wait = 0;
    int            sl_fix = 0;
    bit            sl_mute = 1'b0;
    bit            sl_dat_fix = 1'b0;
    logic [DW-1:0] sl_dat = '0;
    bit            req_on[NCH];
    int            gap[NCH];
    int            acks[NCH];
    bit            gen_en = 1'b0;
    bit            cont = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (s_ack) begin
            s_ack   = 1'b0;
            sl_wait = (sl_fix >= 0) ? sl_fix : int'($urandom_range(0, 3));
        end else if (s_stb && !sl_mute && !rst) begin
            if (sl_wait <= 0) begin
                s_ack = 1'b1;
                s_dti = sl_dat_fix ? sl_dat : DW'($urandom);
            end else sl_wait--;
        end
    endtask

    task automatic masters_auto();
        for (int i = 0; i < NCH; i++) begin
            if (req_on[i]) begin
                if (m_ack[i]) begin
                    m_stb[i]  = 1'b0;
                    req_on[i] = 1'b0;
                    gap[i]    = cont ? 0 : int'($urandom_range(0, 3));
                    acks[i]++;
                end
            end else if (gen_en) begin
                if (gap[i] > 0) gap[i]--;
                else begin
                    m_adr[i*AW +: AW] = AW'($urandom);
                    m_dto[i*DW +: DW] = DW'($urandom);
                    m_wre[i]          = 1'($urandom_range(0, 1));
                    m_stb[i]          = 1'b1;
                    req_on[i]         = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_stb(input string name);
        int n = 0;
        while (!s_stb && n < 10) begin tick(); n++; end
        if (!s_stb) begin n_chk++; $display("FAIL %s: s_stb not raised within 10 cycles", name); end
    endtask

    task automatic wait_ack(input int ch, input string name);
        int n = 0;
        while (!m_ack[ch] && n < 40) begin tick(); n++; end
        check(name, 32'(m_ack[ch]), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded its time limit");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    int  n, stb_n;
    bit  ok;

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dto = '0; m_stb = '0; m_wre = '0;
        s_dti = '0; s_ack = 1'b0;
        for (int i = 0; i < NCH; i++) begin req_on[i] = 1'b0; gap[i] = 0; acks[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // single read on ch0, slave acks in the 2nd BUSY cycle
        sl_fix = 1; sl_wait = 1; sl_dat = 16'hBEEF; sl_dat_fix = 1'b1;
        m_adr[0 +: AW] = 16'h0010; m_wre[0] = 1'b0; m_stb[0] = 1'b1;
        n = 0; stb_n = 0;
        while (!m_ack[0] && n < 40) begin tick(); n++; if (s_stb) stb_n++; end
        check("rd_ack",        32'(m_ack), 32'h1);
        check("rd_stb_cycles", 32'(stb_n), 32'd2);
        check("rd_dti",        32'(m_dti), 32'hBEEF);
        m_stb[0] = 1'b0;
        tick();
        check("rd_ack_one_cycle", 32'(m_ack), 32'h0);

        // write on ch1, fields held for the whole BUSY window
        sl_fix = 3; sl_wait = 3; sl_dat_fix = 1'b0;
        m_adr[AW +: AW] = 16'h1234; m_dto[DW +: DW] = 16'h5678; m_wre[1] = 1'b1; m_stb[1] = 1'b1;
        n = 0; stb_n = 0; ok = 1'b1;
        while (!m_ack[1] && n < 40) begin
            tick(); n++;
            if (s_stb) begin
                stb_n++;
                if (s_adr !== 16'h1234 || s_dto !== 16'h5678 || s_wre !== 1'b1) ok = 1'b0;
            end
        end
        check("wr_ack",         32'(m_ack), 32'h2);
        check("wr_fields_held", 32'(ok),    32'd1);
        check("wr_busy_cycles", 32'(stb_n), 32'd4);
        m_stb[1] = 1'b0; m_wre[1] = 1'b0;
        tick();

        // ch1 pulses and withdraws while ch0 is busy: it must be skipped
        sl_fix = 2; sl_wait = 2;
        m_adr[0 +: AW] = AW'($urandom); m_stb[0] = 1'b1;
        wait_stb("skip_grant");
        m_stb[1] = 1'b1;
        tick();
        m_stb[1] = 1'b0;
        wait_ack(0, "skip_ch0_ack");
        m_stb[0] = 1'b0;
        repeat (6) tick();
        check("skip_idle_after", 32'(s_stb), 32'd0);

        // granted ch1 drops its strobe mid-BUSY: the ack is still delivered
        sl_fix = 1; sl_wait = 1;
        m_adr[AW +: AW] = AW'($urandom); m_stb[1] = 1'b1;
        wait_stb("drop_grant");
        m_stb[1] = 1'b0;
        wait_ack(1, "drop_ack_delivered");
        tick();

        // reset in BUSY: no ack, pointer back to ch1 so ch0 wins the next tie
        sl_mute = 1'b1;
        m_stb[0] = 1'b1;
        wait_stb("rst_grant");
        tick();
        rst = 1'b1; m_stb[0] = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_stb_drop", 32'(s_stb), 32'd0);
        check("rst_no_ack",   32'(m_ack), 32'd0);
        sl_mute = 1'b0; sl_fix = 0; sl_wait = 0;
        m_adr = NCH*AW'($urandom); m_stb = '1;
        n = 0;
        while (m_ack == '0 && n < 40) begin tick(); n++; end
        check("rst_next_winner", 32'(m_ack), 32'h1);
        m_stb = '0;
        tick();

`ifdef DCPU16_MARB_TIMEOUT_EN
        sl_mute = 1'b1;
        m_stb[1] = 1'b1;
        n = 0; stb_n = 0;
        while (m_ack == '0 && n < 60) begin tick(); n++; if (s_stb) stb_n++; end
        check("tmo_busy_cycles", 32'(stb_n), 32'd15);
        check("tmo_ack",         32'(m_ack), 32'h2);
        check("tmo_err",         32'(m_err), 32'h2);
        check("tmo_dti",         32'(m_dti), 32'h0);
        m_stb[1] = 1'b0; sl_mute = 1'b0;
        tick();
`else
        sl_mute = 1'b1;
        m_stb[1] = 1'b1;
        ok = 1'b1;
        tick();
        repeat (40) begin
            tick();
            if (!s_stb || m_ack != '0 || m_err != '0) ok = 1'b0;
        end
        check("no_tmo_stuck", 32'(ok), 32'd1);
        rst = 1'b1; m_stb[1] = 1'b0;
        tick();
        rst = 1'b0; sl_mute = 1'b0;
        tick();
`endif

        // randomized traffic, then both channels saturating
        sl_fix = -1; sl_wait = 0; gen_en = 1'b1; cont = 1'b0;
        repeat (600) begin tick(); masters_auto(); end
        cont = 1'b1;
        repeat (20) begin tick(); masters_auto(); end
        for (int i = 0; i < NCH; i++) acks[i] = 0;
        repeat (300) begin tick(); masters_auto(); end
        check("rr_alternation", 32'((acks[0] - acks[1] <= 1) && (acks[1] - acks[0] <= 1)), 32'd1);
        check("rr_progress",    32'(acks[0] > 20), 32'd1);

        gen_en = 1'b0;
        n = 0;
        while ((req_on[0] || req_on[1]) && n < 100) begin tick(); masters_auto(); n++; end
        check("drain_done", 32'(req_on[0] || req_on[1]), 32'd0);
        repeat (5) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
